mhsa_job_dispatcher: RTL
========================

// Module: mhsa_job_dispatcher
// PURPOSE
//  Multi-channel job front end for the MHSA accelerator: accepts job descriptors from NUM_CH host
//  channels, round-robin arbitrates them onto the single accelerator start/done handshake, runs a
//  per-job watchdog and returns a per-channel completion/error response. Sits between the
//  testbench-facing channel ports and mhsa_acc_wrapper inside the top-level DUT shell.
// PARAMETERS
//  NUM_CH     4   number of host job channels (1..16)
//  ADDR_W     32  width of a job descriptor address
//  TMO_W      16  width of watchdog counter and timeout_cycles port
//  CNT_W      16  width of the completed-job counter
// PORTS
//  clk             in   1               single clock, all logic rising-edge
//  rst             in   1               synchronous, active-high reset
//  req_valid       in   NUM_CH          channel i has a job pending
//  req_addr        in   NUM_CH*ADDR_W   descriptor address, channel i at [i*ADDR_W +: ADDR_W]
//  req_ready       out  NUM_CH          one-hot accept strobe (combinational)
//  acc_start       out  1               one-cycle start pulse to accelerator
//  acc_addr        out  ADDR_W          latched descriptor address of active job
//  acc_abort       out  1               one-cycle abort pulse on watchdog expiry
//  acc_done        in   1               accelerator completion pulse
//  timeout_cycles  in   TMO_W           watchdog limit in cycles; 0 = watchdog disabled
//  rsp_valid       out  NUM_CH          one-hot, one-cycle completion pulse to owning channel
//  rsp_err         out  1               qualifies rsp_valid: 1 = job timed out
//  busy            out  1               high in any state other than IDLE
//  job_cnt         out  CNT_W           jobs completed OK, wraps at 2^CNT_W
//  spurious_done   out  1               sticky: acc_done seen outside RUN
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, rr_ptr=0, acc_start=0, acc_abort=0, acc_addr=0, rsp_valid=0,
//   rsp_err=0, job_cnt=0, spurious_done=0, watchdog=0, grant=0. Reset mid-job drops the job silently
//   (no rsp_valid, no acc_abort).
//  FSM states: IDLE -> START -> RUN -> RESP -> IDLE.
//  IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
//   req_ready[grant]=1 same cycle (combinational, only in IDLE); req_ready=0 otherwise.
//   On accept: latch grant index and req_addr slice into acc_addr, rr_ptr <= grant+1 (mod NUM_CH),
//   go START. No req_valid: stay IDLE.
//  START: acc_start=1 for exactly this one cycle; watchdog cleared; go RUN.
//  RUN: watchdog increments each cycle (saturating at all-ones).
//   acc_done=1 -> go RESP, rsp_err<=0, job_cnt<=job_cnt+1.
//   else if timeout_cycles!=0 and watchdog+1 == timeout_cycles -> acc_abort=1 this cycle, go RESP,
//   rsp_err<=1; job_cnt unchanged. acc_done and expiry same cycle: done wins, no abort.
//  RESP: rsp_valid[grant]=1 for exactly one cycle, rsp_err valid with it; go IDLE.
//  Latency: accept at cycle T -> acc_start at T+1 -> acc_done at D (>=T+2) -> rsp_valid at D+1.
//   Minimum accept-to-accept spacing 4 cycles.
//  acc_done while state!=RUN: ignored for FSM, sets spurious_done (cleared only by rst).
//  acc_addr holds until next accept. rsp_err is 0 whenever rsp_valid==0.
//  Channels must hold req_valid/req_addr stable until req_ready; dispatcher does not check this.
//  Fairness: a continuously requesting channel waits at most NUM_CH-1 other jobs.
// TESTING
//  1 single job: ch2 req_valid, addr 0x1000, acc_done 5 cycles after start -> acc_start 1 cycle
//    after accept, acc_addr=0x1000, rsp_valid=4'b0100, rsp_err=0, job_cnt=1.
//  2 round-robin: all 4 channels valid continuously from reset, done after 3 cycles -> grant order
//    0,1,2,3,0,1; each rsp_valid one-hot matches grant; job_cnt=6.
//  3 timeout: timeout_cycles=10, no acc_done -> acc_abort exactly 10 cycles after acc_start,
//    rsp_err=1, job_cnt unchanged; timeout_cycles=0 same stimulus -> stays RUN, no abort.
//  4 collision: acc_done on the expiry cycle (timeout_cycles=8) -> no acc_abort, rsp_err=0, job_cnt+1.
//  5 spurious/reset: acc_done pulse in IDLE -> spurious_done=1, state IDLE; rst asserted in RUN
//    -> next cycle all outputs at reset values, no rsp_valid emitted for the dropped job.
//  6 wrap: CNT_W=4, 17 successful jobs -> job_cnt=1.

Source files
------------

// File: rtl/mhsa_job_dispatcher.sv
// Multi-channel job front end for the MHSA accelerator: round-robin arbitration of host
// channels onto one start/done handshake, with a per-job watchdog and per-channel responses.
module mhsa_job_dispatcher #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int TMO_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     acc_start,
    output logic [ADDR_W-1:0]        acc_addr,
    output logic                     acc_abort,
    input  logic                     acc_done,
    input  logic [TMO_W-1:0]         timeout_cycles,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         job_cnt,
    output logic                     spurious_done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CH_W-1:0]     rr_ptr_reg;
    logic [CH_W-1:0]     grant_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [TMO_W-1:0]    wd_reg;
    logic                rsp_err_reg;
    logic [CNT_W-1:0]    job_cnt_reg;
    logic                spurious_reg;

    logic [CH_W-1:0]     pick;
    logic                pick_found;
    logic                expire;
    logic [ADDR_W-1:0]   ch_addr [NUM_CH];

    // Per-channel address slices and one-hot decodes of the arbiter pick / owning channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_addr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
        assign req_ready[gi] = (state_reg == IDLE) && pick_found && (pick == CH_W'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == CH_W'(gi));
    end

    // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_CH; iterate backwards so the
    // closest channel to rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [CH_W:0] idx_w;
        pick       = '0;
        pick_found = 1'b0;
        idx_w      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr_reg} + (CH_W+1)'(k);
            if (idx_w >= (CH_W+1)'(NUM_CH)) begin
                idx_w = idx_w - (CH_W+1)'(NUM_CH);
            end
            if (req_valid[idx_w[CH_W-1:0]]) begin
                pick       = idx_w[CH_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign expire = (timeout_cycles != '0) && ((wd_reg + TMO_W'(1)) == timeout_cycles);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = START;
            START:   state_next = RUN;
            RUN:     if (acc_done || expire) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            addr_reg     <= '0;
            wd_reg       <= '0;
            rsp_err_reg  <= 1'b0;
            job_cnt_reg  <= '0;
            spurious_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg  <= pick;
                        addr_reg   <= ch_addr[pick];
                        rr_ptr_reg <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
                    end
                end
                START: wd_reg <= '0;
                RUN: begin
                    if (wd_reg != '1) begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                    // Completion beats a coincident watchdog expiry.
                    if (acc_done) begin
                        rsp_err_reg <= 1'b0;
                        job_cnt_reg <= job_cnt_reg + 1'b1;
                    end else if (expire) begin
                        rsp_err_reg <= 1'b1;
                    end
                end
                RESP:    rsp_err_reg <= 1'b0;
                default: ;
            endcase
            if (acc_done && (state_reg != RUN)) begin
                spurious_reg <= 1'b1;
            end
        end
    end

    assign acc_start     = (state_reg == START);
    assign acc_abort     = (state_reg == RUN) && !acc_done && expire;
    assign acc_addr      = addr_reg;
    assign rsp_err       = rsp_err_reg;
    assign busy          = (state_reg != IDLE);
    assign job_cnt       = job_cnt_reg;
    assign spurious_done = spurious_reg;

endmodule
